// File: rtl/dff_capture_arbiter.sv
// ============================================================================
// Module   : dff_capture_arbiter
// Brief    : Round-robin req/gnt/ack arbiter that owns one shared WIDTH-bit
//            capture register and holds it for HOLD_CYCLES after each capture.
//            Define DFF_CAPTURE_ARBITER_FIXED_PRIO_EN for lowest-index-wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dff_capture_arbiter #(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_REQ-1:0]                      req,
    input  logic [N_REQ*WIDTH-1:0]                req_data,
    output logic [N_REQ-1:0]                      gnt,
    output logic [N_REQ-1:0]                      ack,
    output logic [WIDTH-1:0]                      q,
    output logic                                  q_valid,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] q_owner,
    output logic                                  busy
);

    localparam int                 c_IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0]   c_ONE       = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [7:0]         c_HOLD_INIT = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t               r_state;
    logic [N_REQ-1:0]     r_gnt;
    logic [N_REQ-1:0]     r_ack;
    logic [WIDTH-1:0]     r_q;
    logic                 r_q_valid;
    logic [c_IDX_W-1:0]   r_q_owner;
    logic                 r_busy;
    logic [c_IDX_W-1:0]   r_win;
    logic [7:0]           r_hold_cnt;

    logic                 w_any;
    logic                 w_found;
    logic [c_IDX_W-1:0]   w_win;
    logic [WIDTH-1:0]     w_slice [N_REQ];

    assign w_any = |req;

    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_slice
            assign w_slice[g] = req_data[g*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef DFF_CAPTURE_ARBITER_FIXED_PRIO_EN
    // Descending scan so the lowest set index is the last (winning) write.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[c_IDX_W'(k)]) begin
                w_found = 1'b1;
                w_win   = c_IDX_W'(k);
            end
        end
    end
`else
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic                 w_release;
    logic [c_IDX_W-1:0]   w_next_ptr;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && req[c_IDX_W'((int'(r_rr_ptr) + k) % N_REQ)]) begin
                w_found = 1'b1;
                w_win   = c_IDX_W'((int'(r_rr_ptr) + k) % N_REQ);
            end
        end
    end

    // Pointer advances past the current winner whenever ownership ends,
    // whether by withdrawal in GRANT or by hold expiry.
    assign w_release  = ((r_state == ST_GRANT) && !req[r_win]) ||
                        ((r_state == ST_HOLD) && (r_hold_cnt == 8'd0));
    assign w_next_ptr = (r_win == c_IDX_W'(N_REQ - 1)) ? '0 : r_win + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_release) begin
            r_rr_ptr <= w_next_ptr;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_q        <= '0;
            r_q_valid  <= 1'b0;
            r_q_owner  <= '0;
            r_busy     <= 1'b0;
            r_win      <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any && w_found) begin
                        r_gnt   <= c_ONE << w_win;
                        r_win   <= w_win;
                        r_state <= ST_GRANT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (req[r_win]) begin
                        r_q        <= w_slice[r_win];
                        r_q_owner  <= r_win;
                        r_q_valid  <= 1'b1;
                        r_ack      <= r_gnt;
                        r_hold_cnt <= c_HOLD_INIT;
                        r_state    <= ST_HOLD;
                    end else begin
                        r_gnt   <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (r_hold_cnt != 8'd0) begin
                        r_hold_cnt <= r_hold_cnt - 8'd1;
                    end else begin
                        r_gnt   <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign ack     = r_ack;
    assign q       = r_q;
    assign q_valid = r_q_valid;
    assign q_owner = r_q_owner;
    assign busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_dff_capture_arbiter.sv
// ============================================================================
// Module   : tb_dff_capture_arbiter
// Brief    : Directed scoreboard bench for dff_capture_arbiter (N_REQ=4,
//            WIDTH=8, HOLD_CYCLES=2); captures are checked by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dff_capture_arbiter;

    localparam int N_REQ       = 4;
    localparam int WIDTH       = 8;
    localparam int HOLD_CYCLES = 2;

    logic                   clk    = 1'b0;
    logic                   clk_en = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       q;
    logic                   q_valid;
    logic [1:0]             q_owner;
    logic                   busy;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] owner;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc;

    dff_capture_arbiter #(
        .N_REQ      (N_REQ),
        .WIDTH      (WIDTH),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_data(req_data),
        .gnt     (gnt),
        .ack     (ack),
        .q       (q),
        .q_valid (q_valid),
        .q_owner (q_owner),
        .busy    (busy)
    );

    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] o);
        exp_t e;
        e.data  = d;
        e.owner = o;
        sb_q.push_back(e);
    endtask

    task automatic wait_ack(input string name, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (ack == '0 && cycles < 12);
        if (ack == '0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no ack expected ack within 12 cycles", name);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy !== 1'b0 && n < 12);
        check(name, 32'(busy), 32'd0);
    endtask

    // Monitor: every ack must match the oldest outstanding expected capture.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst !== 1'b1 && ack != '0) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got ack 0x%0h expected none", ack);
                end else begin
                    e = sb_q.pop_front();
                    check("cap_q",     32'(q),       32'(e.data));
                    check("cap_owner", 32'(q_owner), 32'(e.owner));
                    check("cap_ack",   32'(ack),     32'(4'b0001 << e.owner));
                    check("cap_valid", 32'(q_valid), 32'd1);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        req      = '0;
        req_data = '0;

        // Asynchronous reset with the clock stopped.
        #3 rst = 1'b1;
        #1;
        check("rst_gnt",   32'(gnt),     32'd0);
        check("rst_ack",   32'(ack),     32'd0);
        check("rst_q",     32'(q),       32'd0);
        check("rst_valid", 32'(q_valid), 32'd0);
        check("rst_owner", 32'(q_owner), 32'd0);
        check("rst_busy",  32'(busy),    32'd0);
        clk_en = 1'b1;
        #4 rst = 1'b0;

        // Single request with exact latency.
        req      = 4'b0001;
        req_data = 32'h0000_00A5;
        push(8'hA5, 2'd0);
        tick();
        check("t1_gnt",  32'(gnt),  32'h1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ack0", 32'(ack),  32'd0);
        tick();
        check("t1_q",   32'(q),   32'hA5);
        check("t1_ack", 32'(ack), 32'h1);
        req = '0;
        tick();
        check("t1_ack_low",  32'(ack), 32'd0);
        check("t1_gnt_hold", 32'(gnt), 32'h1);
        tick();
        check("t1_gnt_rel",  32'(gnt),  32'd0);
        check("t1_busy_rel", 32'(busy), 32'd0);

        // Round-robin with every requester active.
        rst = 1'b1;
        #1 rst = 1'b0;
        req      = 4'b1111;
        req_data = 32'h1312_1110;
`ifdef DFF_CAPTURE_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < 5; i++) push(8'h10, 2'd0);
`else
        push(8'h10, 2'd0);
        push(8'h11, 2'd1);
        push(8'h12, 2'd2);
        push(8'h13, 2'd3);
        push(8'h10, 2'd0);
`endif
        for (int i = 0; i < 5; i++) begin
            wait_ack("rr_ack", cyc);
            if (i > 0) check("rr_spacing", 32'(cyc), 32'(HOLD_CYCLES + 2));
        end
        req = '0;
        wait_idle("rr_idle");

        // Withdrawal during GRANT: no capture, pointer moves past index 2.
        req_data = 32'h1377_1110;
        req      = 4'b0100;
        tick();
        check("wd_gnt", 32'(gnt), 32'h4);
        req = '0;
        tick();
        check("wd_gnt_clr", 32'(gnt),     32'd0);
        check("wd_ack",     32'(ack),     32'd0);
        check("wd_q",       32'(q),       32'h10);
        check("wd_valid",   32'(q_valid), 32'd1);
        check("wd_owner",   32'(q_owner), 32'd0);
        check("wd_busy",    32'(busy),    32'd0);
        req      = 4'b0110;
        req_data = 32'h1377_5A10;
        push(8'h5A, 2'd1);
        tick();
        check("wd_next_gnt", 32'(gnt), 32'h2);
        wait_ack("wd_next_ack", cyc);
        req = '0;
        wait_idle("wd_idle");

        // Reset during HOLD, then the first grant must start from index 0.
        req      = 4'b0010;
        req_data = 32'h0000_3C00;
        push(8'h3C, 2'd1);
        tick();
        check("rh_gnt", 32'(gnt), 32'h2);
        wait_ack("rh_ack", cyc);
        req = '0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("rh_q",     32'(q),       32'd0);
        check("rh_valid", 32'(q_valid), 32'd0);
        check("rh_gnt0",  32'(gnt),     32'd0);
        check("rh_busy",  32'(busy),    32'd0);
        check("rh_owner", 32'(q_owner), 32'd0);
        check("rh_ack0",  32'(ack),     32'd0);
        #1 rst = 1'b0;
        req      = 4'b1111;
        req_data = 32'h1312_1110;
        push(8'h10, 2'd0);
        tick();
        check("rh_first_gnt", 32'(gnt), 32'h1);
        wait_ack("rh_first_ack", cyc);
        req = '0;
        wait_idle("rh_idle");

        // Data isolation: inputs churn during HOLD without touching q.
        req      = 4'b1000;
        req_data = 32'hC300_0000;
        push(8'hC3, 2'd3);
        tick();
        check("iso_gnt", 32'(gnt), 32'h8);
        wait_ack("iso_ack", cyc);
        req      = 4'b0111;
        req_data = 32'h3CFF_FFFF;
        tick();
        check("iso_q",     32'(q),   32'hC3);
        check("iso_gnt_h", 32'(gnt), 32'h8);
        check("iso_ack0",  32'(ack), 32'd0);
        req      = 4'b1011;
        req_data = 32'h5A5A_5A5A;
        tick();
        check("iso_q2",   32'(q),    32'hC3);
        check("iso_rel",  32'(gnt),  32'd0);
        check("iso_busy", 32'(busy), 32'd0);
        req = '0;
        tick();
        check("iso_idle", 32'(gnt), 32'd0);

        repeat (3) tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dff_capture_arbiter.md
Name: dff_capture_arbiter

Overview:
- Shares one WIDTH-bit D-flip-flop capture register among N_REQ requesters.
- Round-robin arbitration with a req/gnt/ack handshake.
- The granted requester's data is latched into the shared register and held for HOLD_CYCLES before the next grant.
- Sits between multiple producer blocks and the shared flip-flop bank; sequences all capture and ownership of that register.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, capture register width in bits.
- HOLD_CYCLES, 2, cycles q stays owned after capture (1..255).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request, level, held until ack or withdrawn.
- req_data  input  N_REQ*WIDTH  packed data; requester i drives bits [i*WIDTH +: WIDTH].
- gnt  output  N_REQ  one-hot grant, at most one bit set.
- ack  output  N_REQ  one-cycle pulse to the owner on the capture cycle.
- q  output  WIDTH  shared capture register.
- q_valid  output  1  q holds data captured since reset.
- q_owner  output  max(1,$clog2(N_REQ))  index of the last captured requester.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, gnt=0, ack=0, q=0, q_valid=0, q_owner=0, busy=0, rr_ptr=0, hold_cnt=0.
- All outputs are registered; no combinational path from req to gnt or ack.
- States: IDLE, GRANT, HOLD.
- IDLE:
  - If any req bit is set at the edge, choose winner w as the first set bit scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - Set gnt[w]; go to GRANT. Otherwise stay in IDLE.
- GRANT (1 cycle):
  - If req[w] is still 1 at the edge: q <= req_data[w], q_owner <= w, q_valid <= 1, ack[w] pulses for exactly the following cycle, hold_cnt <= HOLD_CYCLES-1, go to HOLD.
  - If req[w] is 0 (withdrawn): clear gnt, leave q/q_valid/q_owner unchanged, rr_ptr <= w+1 mod N_REQ, go to IDLE. No ack.
- HOLD:
  - gnt[w] stays high; req is ignored, including the owner's.
  - While hold_cnt != 0, decrement.
  - At hold_cnt == 0: clear gnt, rr_ptr <= w+1 mod N_REQ, go to IDLE.
- Latency (req first sampled at edge E):
  - gnt visible after E.
  - q and ack visible after E+1.
  - gnt drops after E+1+HOLD_CYCLES.
  - IDLE lasts at least one cycle between grants.
- Back-to-back: requester throughput is one capture per HOLD_CYCLES+2 cycles.
- Fairness: with all requesters continuously requesting, grants cycle 0,1,2,...,N_REQ-1,0; no requester waits more than N_REQ-1 grants.
- rr_ptr wraps from N_REQ-1 to 0.
- Non-owners may change req_data freely; only the winner's slice is sampled, only at the GRANT edge.
- Reset asserted mid-GRANT or mid-HOLD: everything returns to reset values immediately (q cleared, q_valid=0). The pending ack is not issued.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: DFF_CAPTURE_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority, lowest set index wins; rr_ptr is not implemented and stays 0; starvation of high indices is permitted.
- Undefined: round-robin as above.
- Handshake, latency and hold behaviour are identical in both builds.

Test Plan:
- Reset: assert rst mid-cycle with clk stopped -> all outputs 0 immediately, no clock edge needed.
- Single request, N_REQ=4, WIDTH=8, HOLD_CYCLES=2: req=0001, req_data[7:0]=0xA5 at edge 0 ->
  - gnt=0001 after edge 0.
  - q=0xA5, q_valid=1, q_owner=0, ack=0001 after edge 1.
  - ack=0 after edge 2.
  - gnt=0000 and busy=0 after edge 3.
- Round-robin: req=1111 held, data[i]=0x10+i ->
  - q sequence 0x10, 0x11, 0x12, 0x13, 0x10.
  - One ack per grant, captures 4 cycles apart.
  - Under FIXED_PRIO_EN, q stays 0x10 every capture.
- Withdrawal: req=0100 for one edge then 0 ->
  - gnt=0100 for one cycle, then 0.
  - No ack; q/q_valid unchanged.
  - Next req=0110 grants index 3? No: grants index 2's successor scan from rr_ptr=3, so req=0110 -> gnt=0010? Scan 3,0,1 -> index 1 wins, gnt=0010.
- Reset mid-HOLD: req=0010, data 0x3C, rst asserted the cycle after ack -> q=0, q_valid=0, gnt=0 immediately; after rst release, first grant uses rr_ptr=0.
- Data isolation: during HOLD toggle all req_data slices and the owner's req -> q stays constant, gnt stays one-hot on the owner until release.
